// File: rtl/rnbip_ctrl_seq.sv
// rnbip_ctrl_seq: multicycle fetch/decode sequencer driving the RNBIP-2 8x8 register file and ALU.
// Latency (zero-wait memory, FETCH to next FETCH): MOV 3, MVI 4, ALU 4, NOP/illegal 2; HLT is terminal.
// Backpressure: FETCH/OPERAND hold imem_rd=1 and imem_addr=pc until imem_valid; all other states ignore imem_valid.
//
// Ports: clk/clr_n (async active-low), imem_* fetch handshake, we/mux_sel/read_seg/write_seg register file
// controls, OR2 immediate register, alu_op, sticky halted/illegal flags.
// Optional feature macro RNBIP_STEP_EN: adds input step; each step pulse (remembered one deep) releases one fetch.
module rnbip_ctrl_seq #(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                clr_n,
`ifdef RNBIP_STEP_EN
    input  logic                step,
`endif
    input  logic [7:0]          imem_data,
    input  logic                imem_valid,
    output logic                imem_rd,
    output logic [PC_WIDTH-1:0] imem_addr,
    output logic                we,
    output logic [1:0]          mux_sel,
    output logic [2:0]          read_seg,
    output logic [2:0]          write_seg,
    output logic [7:0]          OR2,
    output logic [2:0]          alu_op,
    output logic                halted,
    output logic                illegal
);

    typedef enum logic [2:0] {
        ST_RST     = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_OPERAND = 3'd3,
        ST_EXEC    = 3'd4,
        ST_WB      = 3'd5,
        ST_HALT    = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [7:0]          ir_q, ir_d;
    logic [7:0]          or2_q, or2_d;
    logic                halted_q, halted_d;
    logic                illegal_q, illegal_d;
    logic                fetch_go;

    // Instruction class decode, purely from ir so the controls stay stable DECODE..WB.
    logic [4:0] cls;
    logic [2:0] reg_n;
    logic [4:0] alu_diff;
    logic       is_mov_rn, is_mov_r0, is_mvi, is_alu, is_hlt, is_nop, is_ill;

    assign cls       = ir_q[7:3];
    assign reg_n     = ir_q[2:0];
    assign alu_diff  = cls - 5'd4;
    assign is_mov_rn = (cls == 5'd1);
    assign is_mov_r0 = (cls == 5'd2);
    assign is_mvi    = (cls == 5'd3);
    assign is_alu    = (cls >= 5'd4) && (cls <= 5'd8);
    assign is_hlt    = (cls == 5'd31);
    assign is_nop    = (cls == 5'd0);
    assign is_ill    = !(is_mov_rn || is_mov_r0 || is_mvi || is_alu || is_hlt || is_nop);

`ifdef RNBIP_STEP_EN
    logic step_pend_q, step_pend_d;
    assign fetch_go = step_pend_q;
`else
    assign fetch_go = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= ST_RST;
            pc_q      <= RESET_PC;
            ir_q      <= 8'h00;
            or2_q     <= 8'h00;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
`ifdef RNBIP_STEP_EN
            step_pend_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            or2_q     <= or2_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
`ifdef RNBIP_STEP_EN
            step_pend_q <= step_pend_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        or2_d     = or2_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_RST:   state_d = ST_FETCH;
            ST_FETCH: begin
                if (fetch_go && imem_valid) begin
                    ir_d    = imem_data;
                    pc_d    = pc_q + PC_WIDTH'(1);
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (is_mov_rn || is_mov_r0) begin
                    state_d = ST_WB;
                end else if (is_mvi) begin
                    state_d = ST_OPERAND;
                end else if (is_alu) begin
                    state_d = ST_EXEC;
                end else if (is_hlt) begin
                    halted_d = 1'b1;
                    state_d  = ST_HALT;
                end else begin
                    illegal_d = illegal_q | is_ill;
                    state_d   = ST_FETCH;
                end
            end
            ST_OPERAND: begin
                if (imem_valid) begin
                    or2_d   = imem_data;
                    pc_d    = pc_q + PC_WIDTH'(1);
                    state_d = ST_WB;
                end
            end
            ST_EXEC:  state_d = ST_WB;
            ST_WB:    state_d = ST_FETCH;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_RST;
        endcase
    end

`ifdef RNBIP_STEP_EN
    // A pending step is consumed by the accepted fetch; a new pulse re-arms it (one deep).
    always_comb begin
        step_pend_d = step_pend_q;
        if (state_q == ST_FETCH && step_pend_q && imem_valid) begin
            step_pend_d = 1'b0;
        end
        if (step) begin
            step_pend_d = 1'b1;
        end
    end
`endif

    // Output logic
    always_comb begin
        imem_rd   = ((state_q == ST_FETCH) && fetch_go) || (state_q == ST_OPERAND);
        imem_addr = pc_q;
        we        = (state_q == ST_WB);
        mux_sel   = 2'b00;
        read_seg  = 3'd0;
        write_seg = 3'd0;
        alu_op    = 3'd0;
        if (is_mov_rn) begin
            mux_sel   = 2'b00;
            write_seg = reg_n;
        end else if (is_mov_r0) begin
            mux_sel   = 2'b01;
            write_seg = reg_n;
        end else if (is_mvi) begin
            mux_sel   = 2'b10;
            write_seg = reg_n;
        end else if (is_alu) begin
            // ALU result always lands in R0; RN is presented on port B.
            mux_sel   = 2'b11;
            read_seg  = reg_n;
            write_seg = 3'd0;
            alu_op    = alu_diff[2:0];
        end
        OR2     = or2_q;
        halted  = halted_q;
        illegal = illegal_q;
    end

endmodule

// File: tb/tb_rnbip_ctrl_seq.sv
module tb_rnbip_ctrl_seq;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       valid_en;
    logic [7:0] imem_data;
    logic       imem_valid;
    logic       imem_rd;
    logic [7:0] imem_addr;
    logic       we;
    logic [1:0] mux_sel;
    logic [2:0] read_seg, write_seg, alu_op;
    logic [7:0] or2_out;
    logic       halted, illegal;
    logic [7:0] mem [256];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign imem_data  = mem[imem_addr];
    assign imem_valid = valid_en;

    rnbip_ctrl_seq #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
        .clk        (clk),
        .clr_n      (clr_n),
`ifdef RNBIP_STEP_EN
        .step       (1'b1),
`endif
        .imem_data  (imem_data),
        .imem_valid (imem_valid),
        .imem_rd    (imem_rd),
        .imem_addr  (imem_addr),
        .we         (we),
        .mux_sel    (mux_sel),
        .read_seg   (read_seg),
        .write_seg  (write_seg),
        .OR2        (or2_out),
        .alu_op     (alu_op),
        .halted     (halted),
        .illegal    (illegal)
    );

    typedef struct {
        logic [7:0] op;
        logic [7:0] imm;
        int         len;
        int         cyc;
        bit         we_exp;
        logic [1:0] mux;
        logic [2:0] ws;
        logic [2:0] rs;
        logic [2:0] alu;
        logic [7:0] or2;
        bit         ill;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string tag, input string what, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s.%s got=%0h expected=%0h", tag, what, act, exp);
        end
    endtask

    // Runs one instruction starting at a FETCH negedge for address pc; returns at the next FETCH.
    task automatic exec_one(input vec_t v, input logic [7:0] pc, input string tag);
        logic [7:0] tgt;
        int  cyc;
        int  wes;
        bit  done;
        tgt  = pc + 8'(v.len);
        cyc  = 0;
        wes  = 0;
        done = 0;
        check(tag, "fetch_rd", int'(imem_rd), 1);
        check(tag, "fetch_addr", int'(imem_addr), int'(pc));
        while (!done && cyc < 20) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (we) begin
                wes++;
                if (v.we_exp) begin
                    check(tag, "mux_sel", int'(mux_sel), int'(v.mux));
                    check(tag, "write_seg", int'(write_seg), int'(v.ws));
                    check(tag, "read_seg", int'(read_seg), int'(v.rs));
                    check(tag, "alu_op", int'(alu_op), int'(v.alu));
                end
            end
            if (imem_rd && imem_addr == tgt && !we) done = 1;
        end
        check(tag, "cycles", cyc, v.cyc);
        check(tag, "we_pulses", wes, v.we_exp ? 1 : 0);
        check(tag, "OR2", int'(or2_out), int'(v.or2));
        check(tag, "illegal", int'(illegal), v.ill ? 1 : 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] pc;
        vec_t       v;
        bit         seen;
        clr_n    = 1'b0;
        valid_en = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        //          op     imm    len cyc we  mux    ws    rs    alu   or2    ill
        tbl[0]  = '{8'h1B, 8'h5A, 2, 4, 1, 2'b10, 3'd3, 3'd0, 3'd0, 8'h5A, 0};
        tbl[1]  = '{8'h0D, 8'h00, 1, 3, 1, 2'b00, 3'd5, 3'd0, 3'd0, 8'h5A, 0};
        tbl[2]  = '{8'h22, 8'h00, 1, 4, 1, 2'b11, 3'd0, 3'd2, 3'd0, 8'h5A, 0};
        tbl[3]  = '{8'h16, 8'h00, 1, 3, 1, 2'b01, 3'd6, 3'd0, 3'd0, 8'h5A, 0};
        tbl[4]  = '{8'h2F, 8'h00, 1, 4, 1, 2'b11, 3'd0, 3'd7, 3'd1, 8'h5A, 0};
        tbl[5]  = '{8'h31, 8'h00, 1, 4, 1, 2'b11, 3'd0, 3'd1, 3'd2, 8'h5A, 0};
        tbl[6]  = '{8'h3C, 8'h00, 1, 4, 1, 2'b11, 3'd0, 3'd4, 3'd3, 8'h5A, 0};
        tbl[7]  = '{8'h45, 8'h00, 1, 4, 1, 2'b11, 3'd0, 3'd5, 3'd4, 8'h5A, 0};
        tbl[8]  = '{8'h00, 8'h00, 1, 2, 0, 2'b00, 3'd0, 3'd0, 3'd0, 8'h5A, 0};
        tbl[9]  = '{8'h1A, 8'hC3, 2, 4, 1, 2'b10, 3'd2, 3'd0, 3'd0, 8'hC3, 0};
        tbl[10] = '{8'h80, 8'h00, 1, 2, 0, 2'b00, 3'd0, 3'd0, 3'd0, 8'hC3, 1};
        tbl[11] = '{8'h00, 8'h00, 1, 2, 0, 2'b00, 3'd0, 3'd0, 3'd0, 8'hC3, 1};
        tbl[12] = '{8'h00, 8'h00, 1, 2, 0, 2'b00, 3'd0, 3'd0, 3'd0, 8'hC3, 1};
        tbl[13] = '{8'h00, 8'h00, 1, 2, 0, 2'b00, 3'd0, 3'd0, 3'd0, 8'hC3, 1};

        pc = 8'h00;
        for (int i = 0; i < 14; i++) begin
            mem[pc] = tbl[i].op;
            if (tbl[i].len == 2) mem[pc + 8'd1] = tbl[i].imm;
            pc = pc + 8'(tbl[i].len);
        end
        mem[8'h10] = 8'h09;   // MOV R1,R0
        mem[8'hFF] = 8'h1C;   // MVI R4, imm taken from address 0x00

        // Reset state
        #2;
        check("reset", "we", int'(we), 0);
        check("reset", "imem_rd", int'(imem_rd), 0);
        check("reset", "mux_sel", int'(mux_sel), 0);
        check("reset", "read_seg", int'(read_seg), 0);
        check("reset", "write_seg", int'(write_seg), 0);
        check("reset", "alu_op", int'(alu_op), 0);
        check("reset", "OR2", int'(or2_out), 0);
        check("reset", "halted", int'(halted), 0);
        check("reset", "illegal", int'(illegal), 0);
        @(negedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        @(posedge clk);
        @(negedge clk);

        pc = 8'h00;
        for (int i = 0; i < 14; i++) begin
            exec_one(tbl[i], pc, $sformatf("vec%0d", i));
            pc = pc + 8'(tbl[i].len);
        end

        // Wait states during FETCH at 0x10
        valid_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("stall", "imem_rd", int'(imem_rd), 1);
            check("stall", "imem_addr", int'(imem_addr), 8'h10);
            check("stall", "we", int'(we), 0);
        end
        valid_en = 1'b1;
        v = '{8'h09, 8'h00, 1, 3, 1, 2'b00, 3'd1, 3'd0, 3'd0, 8'hC3, 1};
        exec_one(v, 8'h10, "stall_mov");

        // NOPs up to 0xFE, then MVI across the wrap
        v = '{8'h00, 8'h00, 1, 2, 0, 2'b00, 3'd0, 3'd0, 3'd0, 8'hC3, 1};
        for (int a = 8'h11; a <= 8'hFE; a++) exec_one(v, 8'(a), "nop_run");
        v = '{8'h1C, 8'h1B, 2, 4, 1, 2'b10, 3'd4, 3'd0, 3'd0, 8'h1B, 1};
        exec_one(v, 8'hFF, "wrap_mvi");

        // Illegal, MOV, then HLT
        mem[0] = 8'h80;
        mem[1] = 8'h0D;
        mem[2] = 8'hF8;
        do_reset();
        check("rst2", "illegal", int'(illegal), 0);
        check("rst2", "OR2", int'(or2_out), 0);
        v = '{8'h80, 8'h00, 1, 2, 0, 2'b00, 3'd0, 3'd0, 3'd0, 8'h00, 1};
        exec_one(v, 8'h00, "ill");
        v = '{8'h0D, 8'h00, 1, 3, 1, 2'b00, 3'd5, 3'd0, 3'd0, 8'h00, 1};
        exec_one(v, 8'h01, "mov_after_ill");
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check("halt", "halted", int'(halted), 1);
            check("halt", "imem_rd", int'(imem_rd), 0);
            check("halt", "we", int'(we), 0);
            @(posedge clk);
            @(negedge clk);
        end

        // Reset pulled mid-WB of a MOV following an illegal opcode
        do_reset();
        check("rst3", "halted", int'(halted), 0);
        v = '{8'h80, 8'h00, 1, 2, 0, 2'b00, 3'd0, 3'd0, 3'd0, 8'h00, 1};
        exec_one(v, 8'h00, "ill2");
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (we) seen = 1;
        end
        check("midwb", "we_seen", int'(seen), 1);
        clr_n = 1'b0;
        #1;
        check("midwb", "we", int'(we), 0);
        check("midwb", "illegal", int'(illegal), 0);
        check("midwb", "halted", int'(halted), 0);
        check("midwb", "imem_rd", int'(imem_rd), 0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout sim_time_limit");
        $fatal(1, "timeout");
    end

endmodule
